// File: rtl/rom_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rom_fetch_ctrl_pkg
// Definitions shared by the ROM fetch controller:
//   FETCH_ADDR_W - default ROM address width (4K words)
//   ST_*         - controller state encodings
// ---------------------------------------------------------------------------
package rom_fetch_ctrl_pkg;

    localparam int unsigned FETCH_ADDR_W = 12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/rom_fetch_ctrl_pc_counter.sv
// ---------------------------------------------------------------------------
// pc_counter
// Program counter with load and increment controls. Load wins over
// increment. The increment wraps modulo 2^ADDR_W.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset, clears the counter
//   load     - load strobe, pc <= load_val
//   load_val - value to load
//   inc      - increment strobe, pc <= pc + 1
//   pc       - current counter value
// ---------------------------------------------------------------------------
module pc_counter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg <= '0;
        end else if (load) begin
            pc_reg <= load_val;
        end else if (inc) begin
            pc_reg <= pc_reg + ADDR_W'(1);
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// rom_fetch_ctrl
// Fetches 8-bit words from an external combinational ROM and hands them to a
// consumer over a valid/ready handshake, split into a 4-bit instruction and
// a 4-bit operand. One word per two cycles when the consumer is always ready.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   enable     - run request; fetching proceeds while high
//   load       - PC load strobe (honoured in IDLE and DONE only)
//   load_addr  - value loaded into the PC
//   rom_addr   - ROM address, always equal to the PC
//   rom_data   - ROM word for rom_addr, same cycle
//   out_valid  - fetched word available
//   out_ready  - consumer accepts the word
//   instr      - upper nibble of the fetched word
//   oprnd      - lower nibble of the fetched word
//   done       - high while parked at the end of the program region
// ---------------------------------------------------------------------------
module rom_fetch_ctrl
    import rom_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] END_ADDR = {ADDR_W{1'b1}},
    parameter bit                WRAP     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        instr,
    output logic [3:0]        oprnd,
    output logic              done
);

    logic [1:0]        state_reg, state_next;
    logic              end_reached_reg;
    logic              out_valid_reg;
    logic [3:0]        instr_reg;
    logic [3:0]        oprnd_reg;

    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc;

    pc_counter #(
        .ADDR_W(ADDR_W)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // Next state and PC controls.
    always_comb begin
        state_next  = state_reg;
        pc_load     = 1'b0;
        pc_load_val = load_addr;
        pc_inc      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (load) begin
                    pc_load = 1'b1;
                end else if (enable) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // The fetch always completes, even if enable has dropped.
                state_next = ST_HOLD;
                if (pc != END_ADDR) begin
                    pc_inc = 1'b1;
                end else if (WRAP) begin
                    pc_load     = 1'b1;
                    pc_load_val = '0;
                end
                // Without WRAP the PC parks on END_ADDR.
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (end_reached_reg) begin
                        state_next = ST_DONE;
                    end else if (enable) begin
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (load) begin
                    pc_load    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            end_reached_reg <= 1'b0;
            out_valid_reg   <= 1'b0;
            instr_reg       <= '0;
            oprnd_reg       <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_FETCH: begin
                    out_valid_reg <= 1'b1;
                    instr_reg     <= rom_data[7:4];
                    oprnd_reg     <= rom_data[3:0];
                    if ((pc == END_ADDR) && !WRAP) begin
                        end_reached_reg <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (load) begin
                        end_reached_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_addr  = pc;
    assign out_valid = out_valid_reg;
    assign instr     = instr_reg;
    assign oprnd     = oprnd_reg;
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rom_fetch_ctrl
// Three instances share the stimulus: u_dut (defaults), u_stop (END_ADDR=3,
// no wrap) and u_wrap (END_ADDR=3, wrap). Each has its own ROM model.
// ---------------------------------------------------------------------------
module tb_rom_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [11:0] load_addr;
    logic        out_ready;

    logic [11:0] rom_addr_d, rom_addr_s, rom_addr_w;
    logic [7:0]  rom_data_d, rom_data_s, rom_data_w;
    logic        out_valid_d, out_valid_s, out_valid_w;
    logic [3:0]  instr_d, instr_s, instr_w;
    logic [3:0]  oprnd_d, oprnd_s, oprnd_w;
    logic        done_d, done_s, done_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_word(input logic [11:0] a);
        case (a)
            12'h000: rom_word = 8'hA5;
            12'h001: rom_word = 8'h3C;
            12'h002: rom_word = 8'h7E;
            12'h003: rom_word = 8'hD2;
            12'h010: rom_word = 8'h96;
            default: rom_word = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    assign rom_data_d = rom_word(rom_addr_d);
    assign rom_data_s = rom_word(rom_addr_s);
    assign rom_data_w = rom_word(rom_addr_w);

    rom_fetch_ctrl u_dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .load_addr(load_addr), .rom_addr(rom_addr_d), .rom_data(rom_data_d),
        .out_valid(out_valid_d), .out_ready(out_ready), .instr(instr_d),
        .oprnd(oprnd_d), .done(done_d)
    );

    rom_fetch_ctrl #(.ADDR_W(12), .END_ADDR(12'h003), .WRAP(1'b0)) u_stop (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .load_addr(load_addr), .rom_addr(rom_addr_s), .rom_data(rom_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .instr(instr_s),
        .oprnd(oprnd_s), .done(done_s)
    );

    rom_fetch_ctrl #(.ADDR_W(12), .END_ADDR(12'h003), .WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .load_addr(load_addr), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
        .out_valid(out_valid_w), .out_ready(out_ready), .instr(instr_w),
        .oprnd(oprnd_w), .done(done_w)
    );

    typedef struct {
        logic        ld;
        logic        en;
        logic        rdy;
        logic [11:0] la;
        logic [11:0] e_addr;
        logic        e_valid;
        logic [3:0]  e_instr;
        logic [3:0]  e_oprnd;
        logic        e_done;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic ld, input logic en, input logic rdy,
                                input logic [11:0] la, input logic [11:0] e_addr,
                                input logic e_valid, input logic [3:0] e_instr,
                                input logic [3:0] e_oprnd, input logic e_done);
        vec_t v;
        v.ld = ld; v.en = en; v.rdy = rdy; v.la = la;
        v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
        v.e_oprnd = e_oprnd; v.e_done = e_done;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; load = 1'b0; load_addr = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [31:0] pack_d();
        return 32'({rom_addr_d, out_valid_d, instr_d, oprnd_d, done_d});
    endfunction

    initial begin
        logic [7:0] ws[4];
        logic [7:0] ww[5];
        logic [7:0] exp_s[4];
        logic [7:0] exp_w[5];
        int ns;
        int nw;

        exp_s[0] = 8'hA5; exp_s[1] = 8'h3C; exp_s[2] = 8'h7E; exp_s[3] = 8'hD2;
        exp_w[0] = 8'hA5; exp_w[1] = 8'h3C; exp_w[2] = 8'h7E; exp_w[3] = 8'hD2;
        exp_w[4] = 8'hA5;

        //              ld en rdy la       addr     v  in    op    d
        vecs[0]  = mk(0, 0, 1, 12'h000, 12'h000, 0, 4'h0, 4'h0, 0);
        vecs[1]  = mk(0, 1, 1, 12'h000, 12'h000, 0, 4'h0, 4'h0, 0);
        vecs[2]  = mk(0, 1, 1, 12'h000, 12'h001, 1, 4'hA, 4'h5, 0);
        vecs[3]  = mk(0, 1, 1, 12'h000, 12'h001, 0, 4'hA, 4'h5, 0);
        vecs[4]  = mk(0, 1, 1, 12'h000, 12'h002, 1, 4'h3, 4'hC, 0);
        vecs[5]  = mk(0, 0, 1, 12'h000, 12'h002, 0, 4'h3, 4'hC, 0);
        vecs[6]  = mk(1, 1, 1, 12'h010, 12'h010, 0, 4'h3, 4'hC, 0);
        vecs[7]  = mk(0, 1, 1, 12'h010, 12'h010, 0, 4'h3, 4'hC, 0);
        vecs[8]  = mk(0, 1, 0, 12'h010, 12'h011, 1, 4'h9, 4'h6, 0);
        vecs[9]  = mk(0, 1, 0, 12'h000, 12'h011, 1, 4'h9, 4'h6, 0);
        vecs[10] = mk(1, 1, 0, 12'h0FF, 12'h011, 1, 4'h9, 4'h6, 0);
        vecs[11] = mk(0, 1, 0, 12'h000, 12'h011, 1, 4'h9, 4'h6, 0);
        vecs[12] = mk(0, 1, 0, 12'h000, 12'h011, 1, 4'h9, 4'h6, 0);
        vecs[13] = mk(0, 1, 0, 12'h000, 12'h011, 1, 4'h9, 4'h6, 0);
        vecs[14] = mk(0, 0, 1, 12'h000, 12'h011, 0, 4'h9, 4'h6, 0);
        vecs[15] = mk(0, 1, 1, 12'h000, 12'h011, 0, 4'h9, 4'h6, 0);
        vecs[16] = mk(1, 0, 1, 12'h0AA, 12'h012, 1, 4'h4, 4'hB, 0);
        vecs[17] = mk(0, 0, 1, 12'h000, 12'h012, 0, 4'h4, 4'hB, 0);

        // Reset state, sampled while reset is still asserted.
        reset = 1'b0; enable = 1'b0; load = 1'b0; load_addr = '0; out_ready = 1'b0;
        #12;
        check("reset_state", pack_d(), 32'h0);
        do_reset();

        // Table-driven: basic fetch, load priority, HOLD stall, ignored load.
        for (int i = 0; i < 18; i++) begin
            load      = vecs[i].ld;
            enable    = vecs[i].en;
            out_ready = vecs[i].rdy;
            load_addr = vecs[i].la;
            step();
            check($sformatf("vec%0d", i), pack_d(),
                  32'({vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_instr,
                       vecs[i].e_oprnd, vecs[i].e_done}));
        end

        // End-of-region: stop instance and wrap instance.
        do_reset();
        enable = 1'b1; out_ready = 1'b1;
        ns = 0; nw = 0;
        for (int c = 0; c < 60 && !(done_s && nw >= 5); c++) begin
            step();
            if (out_valid_s) begin
                if (ns < 4) ws[ns] = {instr_s, oprnd_s};
                ns++;
            end
            if (out_valid_w) begin
                if (nw < 5) ww[nw] = {instr_w, oprnd_w};
                nw++;
            end
        end
        check("stop_done_reached", 32'(done_s), 32'd1);
        check("stop_word_count", 32'(ns), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < ns) check($sformatf("stop_word%0d", i), 32'(ws[i]), 32'(exp_s[i]));
        for (int i = 0; i < 5; i++)
            if (i < nw) check($sformatf("wrap_word%0d", i), 32'(ww[i]), 32'(exp_w[i]));
        check("wrap_word_count", 32'(nw >= 5), 32'd1);
        check("wrap_no_done", 32'(done_w), 32'd0);
        check("stop_pc_parked", 32'({rom_addr_s, out_valid_s}), 32'({12'h003, 1'b0}));
        step();
        check("stop_done_holds", 32'({done_s, out_valid_s}), 32'({1'b1, 1'b0}));
        load = 1'b1; load_addr = 12'h000;
        step();
        load = 1'b0;
        check("stop_load_exit", 32'({done_s, rom_addr_s}), 32'({1'b0, 12'h000}));
        step();
        step();
        check("stop_refetch", 32'({out_valid_s, instr_s, oprnd_s}), 32'({1'b1, 8'hA5}));

        // Asynchronous reset in the middle of HOLD.
        do_reset();
        enable = 1'b1; out_ready = 1'b0;
        step(); step(); step();
        check("hold_before_reset", 32'({rom_addr_d, out_valid_d, instr_d, oprnd_d}),
              32'({12'h001, 1'b1, 8'hA5}));
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_clears", pack_d(), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1; out_ready = 1'b1;
        step(); step();
        check("resume_after_reset", pack_d(), 32'({12'h001, 1'b1, 8'hA5, 1'b0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
